// File: rtl/tx_arbiter.sv
// tx_arbiter
// Shares the single transmit packet buffer and the mac_tx_ifc doorbell among
// N_REQ packet producers. A round-robin grant selects one producer. Only that
// producer's byte writes reach the buffer. When the producer signals done,
// the arbiter waits for the transmitter to be idle and rings the doorbell
// once. It then waits for transmission to start before granting again.
//
// Optional build macro: TX_ARB_WATCHDOG_EN
//   When defined, a grant held for WDOG_CYCLES cycles without done is revoked
//   and err pulses. When undefined, a holder may keep the grant indefinitely.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req, done         per-producer request level and completion strobe
//   req_maxaddr       per-producer last byte index, sampled with done
//   req_we/addr/data  per-producer buffer write port
//   grant             one-hot (or zero) grant
//   buf_we/addr/data  write port to the tx packet buffer (holder's port)
//   tx_maxaddr        last byte index handed to mac_tx_ifc
//   tx_doorbell       single-cycle send pulse to mac_tx_ifc
//   tx_available      mac_tx_ifc idle/ready
//   busy              high whenever the arbiter is not idle
//   err               single-cycle pulse on an aborted packet
module tx_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 11,
    parameter int ETH_MTU     = 1518,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        done,
    input  logic [N_REQ*ADDR_W-1:0] req_maxaddr,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*8-1:0]      req_data,
    output logic [N_REQ-1:0]        grant,
    output logic                    buf_we,
    output logic [ADDR_W-1:0]       buf_addr,
    output logic [7:0]              buf_data,
    output logic [ADDR_W-1:0]       tx_maxaddr,
    output logic                    tx_doorbell,
    input  logic                    tx_available,
    output logic                    busy,
    output logic                    err
);

    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAX_ADDR = ETH_MTU - 1;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_AVAIL, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   holder_q, holder_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]  tx_maxaddr_q, tx_maxaddr_d;
    logic               doorbell_q, doorbell_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  hold_addr;
    logic [ADDR_W-1:0]  hold_maxaddr;
    logic [7:0]         hold_data;
    logic               hold_we;
    logic               hold_req;
    logic               hold_done;
    logic               in_grant;
    logic               revoke;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    int                 cand;

    // Current holder's request/write signals, selected by its index.
    assign in_grant     = (state_q == GRANT);
    assign hold_addr    = req_addr[int'(holder_q)*ADDR_W +: ADDR_W];
    assign hold_maxaddr = req_maxaddr[int'(holder_q)*ADDR_W +: ADDR_W];
    assign hold_data    = req_data[int'(holder_q)*8 +: 8];
    assign hold_we      = req_we[holder_q];
    assign hold_req     = req[holder_q];
    assign hold_done    = done[holder_q];
    assign next_ptr     = (int'(holder_q) == N_REQ - 1) ? '0 : holder_q + 1'b1;

`ifdef TX_ARB_WATCHDOG_EN
    localparam int WD_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    logic [WD_W-1:0] wdog_q, wdog_d;

    // Revocation fires on the last allowed grant cycle. A done or a request
    // withdrawal on that same cycle takes priority.
    assign revoke = in_grant && hold_req && !hold_done &&
                    (int'(wdog_q) == WDOG_CYCLES - 1);
`else
    assign revoke = 1'b0;
`endif

    // Buffer writes pass through only for the holder while granted. Writes
    // outside the buffer and writes on a revoke cycle are dropped.
    assign buf_we   = in_grant && hold_we && (int'(hold_addr) <= MAX_ADDR) && !revoke;
    assign buf_addr = in_grant ? hold_addr : '0;
    assign buf_data = in_grant ? hold_data : '0;

    // Round-robin search: the first set request at or after the pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr_q) + i) % N_REQ;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Next-state logic. Every exit from GRANT clears the grant and advances
    // the pointer past the holder, whether the packet was sent or aborted.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        holder_d     = holder_q;
        ptr_d        = ptr_q;
        tx_maxaddr_d = tx_maxaddr_q;
        doorbell_d   = 1'b0;
        err_d        = 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
        wdog_d       = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_available && pick_found) begin
                    grant_d  = N_REQ'(1) << pick_idx;
                    holder_d = pick_idx;
                    state_d  = GRANT;
`ifdef TX_ARB_WATCHDOG_EN
                    wdog_d   = '0;
`endif
                end
            end
            GRANT: begin
`ifdef TX_ARB_WATCHDOG_EN
                wdog_d = wdog_q + 1'b1;
`endif
                if (hold_done) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    if (int'(hold_maxaddr) <= MAX_ADDR) begin
                        tx_maxaddr_d = hold_maxaddr;
                        state_d      = WAIT_AVAIL;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (!hold_req) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else if (revoke) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_AVAIL: begin
                if (tx_available) begin
                    doorbell_d = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only once the transmitter has gone busy. IDLE then
                // holds off new grants until it is available again.
                if (!tx_available) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            holder_q     <= '0;
            ptr_q        <= '0;
            tx_maxaddr_q <= '0;
            doorbell_q   <= 1'b0;
            err_q        <= 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            holder_q     <= holder_d;
            ptr_q        <= ptr_d;
            tx_maxaddr_q <= tx_maxaddr_d;
            doorbell_q   <= doorbell_d;
            err_q        <= err_d;
`ifdef TX_ARB_WATCHDOG_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign tx_maxaddr  = tx_maxaddr_q;
    assign tx_doorbell = doorbell_q;
    assign err         = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter
// Directed test of tx_arbiter with two requesters. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// Reset behaviour, round-robin rotation, write forwarding and filtering,
// oversize-packet abort, transmitter back-pressure, reset aborts, and
// grant hold or revoke are exercised. Revoke is checked when
// TX_ARB_WATCHDOG_EN is defined.
module tb_tx_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 11;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        done;
    logic [N_REQ*ADDR_W-1:0] req_maxaddr;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*8-1:0]      req_data;
    logic [N_REQ-1:0]        grant;
    logic                    buf_we;
    logic [ADDR_W-1:0]       buf_addr;
    logic [7:0]              buf_data;
    logic [ADDR_W-1:0]       tx_maxaddr;
    logic                    tx_doorbell;
    logic                    tx_available;
    logic                    busy;
    logic                    err;

    int checks   = 0;
    int failures = 0;

    tx_arbiter #(
        .N_REQ      (N_REQ),
        .ADDR_W     (ADDR_W),
        .ETH_MTU    (1518),
        .WDOG_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .req_maxaddr (req_maxaddr),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .grant       (grant),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .tx_maxaddr  (tx_maxaddr),
        .tx_doorbell (tx_doorbell),
        .tx_available(tx_available),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] d, input logic ta);
        req          = r;
        done         = d;
        tx_available = ta;
    endtask

    task automatic setWrite(input int p, input logic we, input logic [10:0] addr, input logic [7:0] data);
        req_we[p]             = we;
        req_addr[p*11 +: 11]  = addr;
        req_data[p*8 +: 8]    = data;
    endtask

    task automatic setMaxaddr(input int p, input logic [10:0] maxaddr);
        req_maxaddr[p*11 +: 11] = maxaddr;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = '0; done = '0; req_we = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Holder p writes n bytes at addresses 0..n-1. The other requester writes
    // at the same time and must not be seen. done and maxaddr accompany the
    // last byte.
    task automatic sendPacket(input int p, input int n, input logic [10:0] maxaddr);
        for (int i = 0; i < n; i++) begin
            setWrite(p, 1'b1, 11'(i), 8'(8'h40 + i + p * 16));
            setWrite(1 - p, 1'b1, 11'(200 + i), 8'hEE);
            if (i == n - 1) begin
                done[p] = 1'b1;
                setMaxaddr(p, maxaddr);
            end
            #1;
            checkOutput("pkt_we", 32'(buf_we), 32'd1);
            checkOutput("pkt_addr", 32'(buf_addr), 32'(i));
            checkOutput("pkt_data", 32'(buf_data), 32'(8'(8'h40 + i + p * 16)));
            tick();
        end
        done   = '0;
        req_we = '0;
    endtask

    // Called right after the done edge with tx_available=1. Covers the
    // doorbell two cycles after done, then DRAIN, then IDLE.
    task automatic finishTx(input logic [10:0] exp_max);
        checkOutput("fin_grant0", 32'(grant), 32'd0);
        checkOutput("fin_maxaddr", 32'(tx_maxaddr), 32'(exp_max));
        checkOutput("fin_db_early", 32'(tx_doorbell), 32'd0);
        checkOutput("fin_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("fin_db_pulse", 32'(tx_doorbell), 32'd1);
        tick();
        checkOutput("fin_db_single", 32'(tx_doorbell), 32'd0);
        checkOutput("fin_drain_busy", 32'(busy), 32'd1);
        tx_available = 1'b0;
        tick();
        checkOutput("fin_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic seen;
        logic [1:0] exp_g;
        rst = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b0);
        req_we = '0; req_addr = '0; req_data = '0; req_maxaddr = '0;

        // Reset state
        doReset();
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_doorbell", 32'(tx_doorbell), 32'd0);
        checkOutput("rst_buf_we", 32'(buf_we), 32'd0);
        checkOutput("rst_maxaddr", 32'(tx_maxaddr), 32'd0);

        // Test 1: single packet. There is no grant while tx_available is low.
        applyStimulus(2'b01, 2'b00, 1'b0);
        tick();
        checkOutput("t1_nogrant_unavail", 32'(grant), 32'd0);
        tx_available = 1'b1;
        tick();
        checkOutput("t1_grant", 32'(grant), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        sendPacket(0, 42, 11'd41);
        req = 2'b00;
        finishTx(11'd41);

        // Test 2: both requesting. Grants alternate, starting from requester 0.
        doReset();
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            applyStimulus(2'b11, 2'b00, 1'b1);
            tick();
            checkOutput("t2_rotation", 32'(grant), 32'(exp_g));
            sendPacket(k % 2, 10, 11'd9);
            finishTx(11'd9);
        end

        // Test 3: oversize maxaddr gives err, no doorbell, then the next requester.
        applyStimulus(2'b11, 2'b00, 1'b1);
        tick();
        checkOutput("t3_grant0", 32'(grant), 32'd1);
        sendPacket(0, 3, 11'd1600);
        checkOutput("t3_err_pulse", 32'(err), 32'd1);
        checkOutput("t3_grant_clr", 32'(grant), 32'd0);
        checkOutput("t3_idle", 32'(busy), 32'd0);
        tick();
        checkOutput("t3_err_single", 32'(err), 32'd0);
        checkOutput("t3_no_doorbell", 32'(tx_doorbell), 32'd0);
        checkOutput("t3_next_grant", 32'(grant), 32'd2);

        // Buffer address filter at the edge of the buffer
        setWrite(1, 1'b1, 11'd1600, 8'h11);
        #1;
        checkOutput("t3_we_oob", 32'(buf_we), 32'd0);
        setWrite(1, 1'b1, 11'd1517, 8'h12);
        #1;
        checkOutput("t3_we_last", 32'(buf_we), 32'd1);
        checkOutput("t3_addr_last", 32'(buf_addr), 32'd1517);
        req_we = '0;

        // Holder withdraws req without done: abort without err.
        req = 2'b01;
        tick();
        checkOutput("t3_abort_grant", 32'(grant), 32'd0);
        checkOutput("t3_abort_err", 32'(err), 32'd0);
        checkOutput("t3_abort_idle", 32'(busy), 32'd0);
        tick();
        checkOutput("t3_regrant", 32'(grant), 32'd1);

        // done from a non-holder is ignored.
        done = 2'b10;
        setMaxaddr(1, 11'd5);
        tick();
        done = 2'b00;
        checkOutput("t3_nonholder_done", 32'(grant), 32'd1);
        checkOutput("t3_nonholder_busy", 32'(busy), 32'd1);

        // Test 4: transmitter busy at done. Doorbell waits for tx_available.
        tx_available = 1'b0;
        done = 2'b01;
        setMaxaddr(0, 11'd59);
        tick();
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t4_grant_clr", 32'(grant), 32'd0);
        checkOutput("t4_maxaddr", 32'(tx_maxaddr), 32'd59);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (tx_doorbell !== 1'b0 || busy !== 1'b1) seen = 1'b1;
        end
        checkOutput("t4_hold_wait", 32'(seen), 32'd0);
        tx_available = 1'b1;
        tick();
        checkOutput("t4_db_pulse", 32'(tx_doorbell), 32'd1);
        tick();
        checkOutput("t4_db_single", 32'(tx_doorbell), 32'd0);
        tx_available = 1'b0;
        tick();
        checkOutput("t4_idle", 32'(busy), 32'd0);

        // Test 5: reset in GRANT and then reset in WAIT_AVAIL.
        applyStimulus(2'b01, 2'b00, 1'b1);
        tick();
        checkOutput("t5_grant", 32'(grant), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_rst_grant", 32'(grant), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        req = 2'b11;
        tick();
        checkOutput("t5_ptr_zero", 32'(grant), 32'd1);
        tx_available = 1'b0;
        done = 2'b01;
        setMaxaddr(0, 11'd10);
        tick();
        done = 2'b00;
        checkOutput("t5_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tx_available = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b00;
        checkOutput("t5_rst2_db", 32'(tx_doorbell), 32'd0);
        checkOutput("t5_rst2_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst2_maxaddr", 32'(tx_maxaddr), 32'd0);
        tick();
        checkOutput("t5_no_late_db", 32'(tx_doorbell), 32'd0);
        req = 2'b11;
        tick();
        checkOutput("t5_ptr_zero2", 32'(grant), 32'd1);

        // Test 6: holder never sends done.
`ifdef TX_ARB_WATCHDOG_EN
        seen = 1'b0;
        for (int c = 1; c < 16; c++) begin
            tick();
            if (grant !== 2'b01 || err !== 1'b0) seen = 1'b1;
        end
        checkOutput("t6_wd_held", 32'(seen), 32'd0);
        setWrite(0, 1'b1, 11'd3, 8'h55);
        #1;
        checkOutput("t6_wd_we_suppr", 32'(buf_we), 32'd0);
        tick();
        req_we = '0;
        checkOutput("t6_wd_revoke", 32'(grant), 32'd0);
        checkOutput("t6_wd_err", 32'(err), 32'd1);
        tick();
        checkOutput("t6_wd_err_single", 32'(err), 32'd0);
        checkOutput("t6_wd_next", 32'(grant), 32'd2);
`else
        seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (grant !== 2'b01 || err !== 1'b0) seen = 1'b1;
        end
        checkOutput("t6_hold_1000", 32'(seen), 32'd0);
        checkOutput("t6_hold_busy", 32'(busy), 32'd1);
`endif
        req = 2'b00;
        tick();
        checkOutput("t6_release", 32'(grant), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares the single transmit packet buffer and mac_tx_ifc doorbell among N_REQ packet producers (ARP responder, echo service, future laser-telemetry source).
- Round-robin grant; the granted producer alone writes buffer bytes through the arbiter.
- On the producer's done strobe, the arbiter waits for the transmitter, rings the doorbell once, and waits for transmission to start before re-arbitrating.
- Sits between the protocol engines and mac_tx_ifc in the 50 MHz sys_clk domain.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 11, packet buffer byte-address width
ETH_MTU, 1518, buffer depth in bytes; highest legal maxaddr is ETH_MTU-1
WDOG_CYCLES, 4096, grant-hold limit (only with TX_ARB_WATCHDOG_EN)

Ports:
clk  in  1  system clock (sys_clk); one clock domain
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request, level; held until grant or withdrawn
done  in  N_REQ  per-requester completion strobe; honoured only from the current grant holder
req_maxaddr  in  N_REQ*ADDR_W  per-requester last byte index, sampled with done
req_we  in  N_REQ  per-requester buffer write enable
req_addr  in  N_REQ*ADDR_W  per-requester write address
req_data  in  N_REQ*8  per-requester write byte
grant  out  N_REQ  one-hot (or zero) grant
buf_we  out  1  write enable to tx packet buffer
buf_addr  out  ADDR_W  write address
buf_data  out  8  write byte
tx_maxaddr  out  ADDR_W  last byte index to mac_tx_ifc
tx_doorbell  out  1  single-cycle send pulse to mac_tx_ifc
tx_available  in  1  mac_tx_ifc idle/ready
busy  out  1  high in any state other than IDLE
err  out  1  single-cycle pulse on an aborted packet

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0.
  - rst in any state aborts the packet: no doorbell, grant drops on the next edge.
- IDLE: when tx_available=1 and any req bit is set, register grant to the first set req at or after the pointer, wrapping at N_REQ-1→0, and go to GRANT.
  - Grant is visible 1 cycle after req is sampled.
  - If tx_available=0, no grant is issued and requests wait.
- GRANT:
  - buf_we/addr/data are a combinational mux of the holder's req_we/addr/data.
  - Non-holder write inputs are ignored.
  - buf_we is forced to 0 when req_addr > ETH_MTU-1.
  - Holder's done=1 samples req_maxaddr:
    - maxaddr ≤ ETH_MTU-1: latch it into tx_maxaddr and go to WAIT_AVAIL.
    - maxaddr > ETH_MTU-1: pulse err and go to IDLE with no doorbell.
  - Either way, clear grant on the same edge and set pointer = holder+1 (wrapping).
  - A write on the same cycle as done is still forwarded.
  - Holder drops req without done: treat as abort; clear grant, go to IDLE, no err, pointer advances.
- WAIT_AVAIL: when tx_available=1, assert tx_doorbell for exactly one cycle and go to DRAIN.
- DRAIN: tx_doorbell=0; when tx_available=0, go to IDLE.
  - IDLE then blocks further grants until tx_available returns to 1, so the buffer is never written during transmission.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,N_REQ-1,0.
- done from non-holders, and done in non-GRANT states, are ignored.
- Latency from holder done to doorbell: 2 cycles minimum, when tx_available=1.

Optional Feature:
TX_ARB_WATCHDOG_EN:
- Defined:
  - A counter clears on entry to GRANT and increments every GRANT cycle.
  - When it reaches WDOG_CYCLES-1 without done, revoke grant, pulse err, advance pointer, and go to IDLE.
  - A write on the revoke cycle is suppressed.
- Undefined: no counter; a holder may keep the grant indefinitely.

Test Plan:
1. Reset, then req=2'b01, tx_available=1 → grant=01 next cycle. Writes to addr 0..41 appear on buf_*. done with maxaddr=41 → tx_maxaddr=41, single doorbell pulse 2 cycles later. Drop tx_available → busy=0.
2. req=2'b11 held continuously, each holder sending done after 10 writes → grant sequence 01,10,01,10. No write from the non-holder reaches buf_we.
3. done with maxaddr=1600 → err pulses 1 cycle, no doorbell, grant cleared, next requester served.
4. tx_available=0 when done with maxaddr=59 → state holds in WAIT_AVAIL. Raise tx_available after 100 cycles → doorbell on the next cycle only.
5. rst asserted in GRANT and again in WAIT_AVAIL → all outputs 0 next cycle, no doorbell, pointer 0.
6. With TX_ARB_WATCHDOG_EN and WDOG_CYCLES=16, holder never sends done → grant drops after 16 cycles, err pulses, other requester granted; without the macro, grant is held for 1000 cycles.
